sc_bgtimer: RTL and testbench



---
 rtl/sc_bg_pkg.sv | 10 +
 rtl/sc_bgtimer_channel.sv | 56 +++++
 rtl/sc_bgtimer.sv | 81 ++++++++
 tb/tb_sc_bgtimer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sc_bg_pkg.sv
// Shared constants for the background-lane timeout generator.
package sc_bg_pkg;

  localparam int unsigned CNT_WIDTH_DEF       = 24;
  localparam int unsigned LEVEL_WIDTH_DEF     = 2;
  localparam int unsigned SHIFT_CNT_WIDTH     = 8;
  localparam logic [23:0] PERIOD0_BASE_DEF    = 24'd5000000;
  localparam logic [23:0] PERIOD1_DEF         = 24'd1000000;

endpackage

// File: rtl/sc_bgtimer_channel.sv
// One timeout channel: strobe-driven up-counter with a period compare, sticky
// flag, and a combinational fire indication for the edge on which it wraps.
module sc_bgtimer_channel
  import sc_bg_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_ni,
  input  logic                 strobe_ni,
  input  logic [CNT_WIDTH-1:0] period_i,
  output logic                 flag_o,
  output logic                 fire_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 flag_q, flag_d;
  logic                 fire;

  // Next-state: clear wins, then wrap-and-flag, then plain increment, else hold.
  // The >= compare lets a shortened period take effect on the very next strobe.
  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    fire   = 1'b0;
    if (!clear_ni) begin
      cnt_d  = '0;
      flag_d = 1'b0;
    end else if (!strobe_ni) begin
      if (cnt_q >= (period_i - CNT_WIDTH'(1))) begin
        cnt_d  = '0;
        flag_d = 1'b1;
        fire   = 1'b1;
      end else begin
        cnt_d  = cnt_q + CNT_WIDTH'(1);
        flag_d = 1'b0;
      end
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;
  assign fire_o = fire;

endmodule

// File: rtl/sc_bgtimer.sv
// Dual-channel timeout generator: channel 0 period shrinks with level,
// channel 1 period is fixed; also counts channel 0 timeouts mod 256.
module sc_bgtimer
  import sc_bg_pkg::*;
#(
  parameter int unsigned          CNT_WIDTH    = CNT_WIDTH_DEF,
  parameter logic [CNT_WIDTH-1:0] PERIOD0_BASE = PERIOD0_BASE_DEF,
  parameter logic [CNT_WIDTH-1:0] PERIOD1      = PERIOD1_DEF,
  parameter int unsigned          LEVEL_WIDTH  = LEVEL_WIDTH_DEF
) (
  input  logic                       SC_BGTIMER_CLOCK_50,
  input  logic                       SC_BGTIMER_RESET_InLow,
  input  logic                       SC_BGTIMER_clear_InLow,
  input  logic                       SC_BGTIMER_upcount0_InLow,
  input  logic                       SC_BGTIMER_upcount1_InLow,
  input  logic [LEVEL_WIDTH-1:0]     SC_BGTIMER_level_In,
  output logic                       SC_BGTIMER_T0_OutLow,
  output logic                       SC_BGTIMER_T1_OutLow,
  output logic [SHIFT_CNT_WIDTH-1:0] SC_BGTIMER_shiftCount_Out
);

  localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] P1_EFF = (PERIOD1 == '0) ? ONE : PERIOD1;

  logic [CNT_WIDTH-1:0]       p0_shift, p0_eff;
  logic                       flag0, flag1, fire0, fire1;
  logic [SHIFT_CNT_WIDTH-1:0] shift_cnt_q, shift_cnt_d;

  // Level-scaled channel 0 period, never allowed to reach zero.
  always_comb begin
    p0_shift = PERIOD0_BASE >> SC_BGTIMER_level_In;
    p0_eff   = (p0_shift == '0) ? ONE : p0_shift;
  end

  sc_bgtimer_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch0 (
    .clk_i     (SC_BGTIMER_CLOCK_50),
    .rst_ni    (SC_BGTIMER_RESET_InLow),
    .clear_ni  (SC_BGTIMER_clear_InLow),
    .strobe_ni (SC_BGTIMER_upcount0_InLow),
    .period_i  (p0_eff),
    .flag_o    (flag0),
    .fire_o    (fire0)
  );

  sc_bgtimer_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch1 (
    .clk_i     (SC_BGTIMER_CLOCK_50),
    .rst_ni    (SC_BGTIMER_RESET_InLow),
    .clear_ni  (SC_BGTIMER_clear_InLow),
    .strobe_ni (SC_BGTIMER_upcount1_InLow),
    .period_i  (P1_EFF),
    .flag_o    (flag1),
    .fire_o    (fire1)
  );

  // Shift-event count: cleared with the channels, bumped on each channel 0 wrap.
  always_comb begin
    shift_cnt_d = shift_cnt_q;
    if (!SC_BGTIMER_clear_InLow) begin
      shift_cnt_d = '0;
    end else if (fire0) begin
      shift_cnt_d = shift_cnt_q + SHIFT_CNT_WIDTH'(1);
    end
  end

  // Shift-event count register.
  always_ff @(posedge SC_BGTIMER_CLOCK_50 or negedge SC_BGTIMER_RESET_InLow) begin
    if (!SC_BGTIMER_RESET_InLow) begin
      shift_cnt_q <= '0;
    end else begin
      shift_cnt_q <= shift_cnt_d;
    end
  end

  assign SC_BGTIMER_T0_OutLow      = ~flag0;
  assign SC_BGTIMER_T1_OutLow      = ~flag1;
  assign SC_BGTIMER_shiftCount_Out = shift_cnt_q;

  logic unused_fire1;
  assign unused_fire1 = fire1;

endmodule

// File: tb/tb_sc_bgtimer.sv
module tb_sc_bgtimer;

  logic       clk = 1'b0;
  logic       rst_n, clear_n, up0_n, up1_n;
  logic [1:0] level;
  logic       t0_n, t1_n;
  logic [7:0] sc;

  int n_tests = 0;
  int n_fail  = 0;

  sc_bgtimer #(
    .CNT_WIDTH    (24),
    .PERIOD0_BASE (24'd8),
    .PERIOD1      (24'd3),
    .LEVEL_WIDTH  (2)
  ) dut (
    .SC_BGTIMER_CLOCK_50       (clk),
    .SC_BGTIMER_RESET_InLow    (rst_n),
    .SC_BGTIMER_clear_InLow    (clear_n),
    .SC_BGTIMER_upcount0_InLow (up0_n),
    .SC_BGTIMER_upcount1_InLow (up1_n),
    .SC_BGTIMER_level_In       (level),
    .SC_BGTIMER_T0_OutLow      (t0_n),
    .SC_BGTIMER_T1_OutLow      (t1_n),
    .SC_BGTIMER_shiftCount_Out (sc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr_n;
    logic       u0_n;
    logic       u1_n;
    logic [1:0] lv;
    logic       e_t0;
    logic       e_t1;
    logic [7:0] e_sc;
  } vec_t;

  vec_t vt[15];

  task automatic check_out(input string name, input logic e0, input logic e1, input logic [7:0] esc);
    n_tests++;
    if (t0_n !== e0 || t1_n !== e1 || sc !== esc) begin
      n_fail++;
      $display("FAIL %s: got T0=%b T1=%b sc=%0d, want T0=%b T1=%b sc=%0d",
               name, t0_n, t1_n, sc, e0, e1, esc);
    end
  endtask

  // One clock with the given inputs; returns just after the rising edge.
  task automatic step(input logic c, input logic u0, input logic u1, input logic [1:0] lv);
    @(negedge clk);
    clear_n = c; up0_n = u0; up1_n = u1; level = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    step(1'b0, 1'b1, 1'b1, 2'd0);
  endtask

  initial begin
    // clr, u0, u1, lvl -> T0, T1, sc   (P0 at lvl2 = 2, lvl1 = 4, lvl3 = 1; P1 = 3)
    vt[0]  = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 8'd0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 8'd1};
    vt[2]  = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 8'd1};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 8'd1};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 8'd2};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 8'd2};
    vt[6]  = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 8'd2};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 8'd0};
    vt[8]  = '{1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 8'd1};
    vt[9]  = '{1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 8'd2};
    vt[10] = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 8'd2};
    vt[11] = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 8'd2};
    vt[12] = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 8'd2};
    vt[13] = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 8'd3};
    vt[14] = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 8'd0};

    // Asynchronous reset with random strobes, before any clock edge.
    rst_n = 1'b1; clear_n = 1'b1; level = 2'd0;
    up0_n = 1'($urandom_range(0, 1));
    up1_n = 1'($urandom_range(0, 1));
    #1 rst_n = 1'b0;
    #1 check_out("reset_async", 1'b1, 1'b1, 8'd0);
    @(negedge clk);
    rst_n = 1'b1; up0_n = 1'b1; up1_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 2'd0);
    check_out("reset_release_idle", 1'b1, 1'b1, 8'd0);

    // Table-driven vectors.
    for (int i = 0; i < 15; i++) begin
      step(vt[i].clr_n, vt[i].u0_n, vt[i].u1_n, vt[i].lv);
      check_out($sformatf("vec%0d", i), vt[i].e_t0, vt[i].e_t1, vt[i].e_sc);
    end

    // Level 0: eight spaced strobes, sticky flag, 9th strobe restarts count at 1.
    do_clear();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 2'd0);
      if (i == 7) check_out("l0_before_8th", 1'b1, 1'b1, 8'd0);
      step(1'b1, 1'b1, 1'b1, 2'd0);
    end
    check_out("l0_after_8th", 1'b0, 1'b1, 8'd1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b1, 2'd0);
      check_out("l0_sticky", 1'b0, 1'b1, 8'd1);
    end
    step(1'b1, 1'b0, 1'b1, 2'd0);
    check_out("l0_9th_strobe", 1'b1, 1'b1, 8'd1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 2'd0);
    check_out("l0_cnt7", 1'b1, 1'b1, 8'd1);
    step(1'b1, 1'b0, 1'b1, 2'd0);
    check_out("l0_second_timeout", 1'b0, 1'b1, 8'd2);

    // Level raised mid-count past the new period.
    do_clear();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 2'd0);
    check_out("lvlchg_cnt5", 1'b1, 1'b1, 8'd0);
    step(1'b1, 1'b0, 1'b1, 2'd3);
    check_out("lvlchg_fire", 1'b0, 1'b1, 8'd1);
    step(1'b1, 1'b0, 1'b1, 2'd2);
    check_out("lvlchg_cnt0_then1", 1'b1, 1'b1, 8'd1);
    step(1'b1, 1'b0, 1'b1, 2'd2);
    check_out("lvlchg_p2_fire", 1'b0, 1'b1, 8'd2);

    // Clear coincident with the 8th strobe.
    do_clear();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 2'd0);
    step(1'b0, 1'b0, 1'b1, 2'd0);
    check_out("clear_beats_strobe", 1'b1, 1'b1, 8'd0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 2'd0);
    check_out("clear_cnt_restart", 1'b1, 1'b1, 8'd0);
    step(1'b1, 1'b0, 1'b1, 2'd0);
    check_out("clear_then_fire", 1'b0, 1'b1, 8'd1);

    // Level 3: every strobe times out; held strobe for 256 cycles wraps shiftCount.
    do_clear();
    for (int i = 1; i <= 256; i++) begin
      step(1'b1, 1'b0, 1'b1, 2'd3);
      if (i == 255) check_out("wrap_255", 1'b0, 1'b1, 8'd255);
    end
    check_out("wrap_to_0", 1'b0, 1'b1, 8'd0);

    // Simultaneous strobes on both channels.
    do_clear();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 2'd0);
    check_out("simul_t1_fires", 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 2'd0);
    check_out("simul_cnt0_7", 1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b0, 1'b1, 2'd0);
    check_out("simul_t0_fires", 1'b0, 1'b0, 8'd1);

    // Reset asserted mid-count, then counting restarts from zero.
    do_clear();
    step(1'b1, 1'b0, 1'b0, 2'd3);
    step(1'b1, 1'b1, 1'b0, 2'd3);
    check_out("pre_reset", 1'b0, 1'b1, 8'd1);
    @(negedge clk);
    up0_n = 1'b0; up1_n = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_out("reset_mid_seq", 1'b1, 1'b1, 8'd0);
    @(negedge clk);
    rst_n = 1'b1; up0_n = 1'b1; up1_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b1, 1'b0, 2'd0);
    check_out("post_reset_cnt1_2", 1'b1, 1'b1, 8'd0);
    step(1'b1, 1'b1, 1'b0, 2'd0);
    check_out("post_reset_t1_fire", 1'b1, 1'b0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
